prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Sits directly upstream of the HLS RV32I `computer` core and boots it.
- Accepts a 32-bit word stream (valid/ready) and writes it into the core's instruction ROM and data RAM through dedicated write ports. Words 0..2^ADDR_BITS-1 go to imem; the next 2^ADDR_BITS words go to dmem.
- Holds the core in reset during the load, then releases it and supervises the run. It counts cycles until the core asserts halt (computer_ret) or a cycle limit expires.

Parameters:
- ADDR_BITS, 16, word-address width of each memory (each memory holds 2^ADDR_BITS words)
- RST_HOLD, 5, cycles core_rst stays asserted after the load completes
- MAX_CYCLES, 50000, run cycles before timeout
- CNT_W, 32, width of cycle_count

Ports:
- CLOCK  in  1  sole clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; starts a new load from IDLE/DONE/TOUT
- s_valid  in  1  stream word valid
- s_ready  out  1  loader accepts word
- s_data  in  32  stream word
- s_last  in  1  final word of image
- imem_we  out  1  imem write enable
- imem_waddr  out  ADDR_BITS  imem word address
- imem_wdata  out  32  imem write data
- dmem_we  out  1  dmem write enable
- dmem_waddr  out  ADDR_BITS  dmem word address
- dmem_wdata  out  32  dmem write data
- core_rst  out  1  active-high reset to computer.RESET
- core_halt  in  1  computer_ret from core
- busy  out  1  state is LOAD, HOLD or RUN
- done  out  1  core halted normally; sticky until start
- timeout  out  1  MAX_CYCLES reached without halt; sticky until start
- overflow  out  1  image exceeded 2*2^ADDR_BITS words; sticky until start
- cycle_count  out  CNT_W  run cycles counted in RUN

Behaviour:
- Reset (RESET=0, async): state=IDLE, and every other output is cleared. Word pointer and counters clear. The single exception is core_rst=1.
- States: IDLE, LOAD, HOLD, RUN, DONE, TOUT.
- IDLE: core_rst=1, s_ready=0. On start, clear the pointer, cycle_count and all sticky flags, then go to LOAD.
- LOAD: s_ready=1 and core_rst=1. A transfer occurs on s_valid & s_ready.
  - Word pointer ptr, width ADDR_BITS+1. ptr MSB=0 writes imem; MSB=1 writes dmem. The low ADDR_BITS bits are the address.
  - Writes are registered: we/addr/data appear the cycle after the transfer, for one cycle.
  - ptr increments per transfer.
  - Transfer with s_last goes to HOLD.
- Overflow:
  - A transfer while ptr has wrapped to 2^(ADDR_BITS+1) writes nothing and sets overflow.
  - The loader keeps accepting words (draining) until s_last, then goes to HOLD.
- Single-word image: a transfer with s_last at ptr=0 writes imem[0] and goes to HOLD.
- HOLD: core_rst=1 for exactly RST_HOLD cycles (internal counter), then RUN. core_halt is ignored in HOLD.
- RUN: core_rst=0 and cycle_count increments each cycle.
  - core_halt=1 goes to DONE; done=1 from the next cycle.
  - cycle_count==MAX_CYCLES-1 goes to TOUT; timeout=1.
  - Halt and limit in the same cycle: halt wins (DONE).
  - cycle_count saturates and never wraps.
- DONE/TOUT:
  - DONE: core_rst=0; the core stays halted and observable.
  - TOUT: core_rst=1.
  - Both hold until start.
- start is ignored in LOAD/HOLD/RUN.
- Async reset mid-load or mid-run: outputs clear immediately and core_rst asserts immediately. Partially written memory contents are not the loader's concern.
- s_ready is registered from state, not combinationally from s_valid.

Optional Feature:
- Macro LOADER_CHECKSUM_EN.
- Defined:
  - Adds output checksum[31:0], the modulo-2^32 sum of every accepted word, including overflow-discarded words.
  - Cleared on reset and on start; valid from entry to HOLD.
- Undefined: no checksum port or adder; all other behaviour identical.

Test Plan:
- Image 6 words (0x00500093, 0x00A00113, 0x002081B3, 0x00302023, 0x00000073, 0x0) with s_last on word 5 → imem_we pulses for addr 0..5 with matching data; dmem_we never pulses; core_rst low exactly 5 cycles after the last transfer.
- Image 65536+3 words, s_valid gapped every other cycle → imem addr 0..65535, then dmem addr 0,1,2; overflow=0.
- Core model asserts halt 120 cycles after core_rst falls → done=1, cycle_count=120, busy=0, core_rst stays 0.
- Core never halts, MAX_CYCLES=1000 → timeout=1 with cycle_count=999; core_rst=1; halt pulsed in that same limit cycle instead → done=1, timeout=0.
- ADDR_BITS=2, 10-word image → 8 writes (4 imem, 4 dmem); words 9-10 accepted but not written; overflow=1; checksum (if LOADER_CHECKSUM_EN) = sum of all 10 words.
- RESET low during LOAD after 3 words → all outputs reset; core_rst=1; start after release reloads from ptr 0; start pulsed during RUN is ignored.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: boot loader and run supervisor for the HLS RV32I core.
// Streams a word image into imem then dmem, holds the core in reset while
// loading, releases it, and counts run cycles until halt or a cycle limit.
// Optional build macro: LOADER_CHECKSUM_EN adds a running 32-bit sum of
// every accepted stream word on the checksum output.
module prog_loader #(
  parameter int ADDR_BITS  = 16,
  parameter int RST_HOLD   = 5,
  parameter int MAX_CYCLES = 50000,
  parameter int CNT_W      = 32
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 start,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  input  logic                 s_last,
  output logic                 imem_we,
  output logic [ADDR_BITS-1:0] imem_waddr,
  output logic [31:0]          imem_wdata,
  output logic                 dmem_we,
  output logic [ADDR_BITS-1:0] dmem_waddr,
  output logic [31:0]          dmem_wdata,
  output logic                 core_rst,
  input  logic                 core_halt,
  output logic                 busy,
  output logic                 done,
  output logic                 timeout,
  output logic                 overflow,
  output logic [CNT_W-1:0]     cycle_count
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]          checksum
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_HOLD = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_TOUT = 3'd5;

  localparam int HOLD_W = (RST_HOLD > 2) ? $clog2(RST_HOLD) : 1;

  logic [2:0]          state;
  logic [2:0]          state_next;
  logic [ADDR_BITS:0]  ptr;
  logic                ptr_wrapped;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                xfer;
  logic                xfer_write;
  logic                start_load;
  logic                hold_last;
  logic                at_limit;
  logic                cnt_saturated;

  // Handshake and qualifier decode shared by the sequential blocks below
  always_comb begin
    xfer          = s_valid && s_ready;
    xfer_write    = xfer && !ptr_wrapped;
    start_load    = start && ((state == S_IDLE) || (state == S_DONE) ||
                              (state == S_TOUT));
    hold_last     = (hold_cnt == HOLD_W'(RST_HOLD - 1));
    at_limit      = (cycle_count == CNT_W'(MAX_CYCLES - 1));
    cnt_saturated = (cycle_count == {CNT_W{1'b1}});
  end

  // Status outputs are pure decodes of the state register, so they never
  // depend combinationally on stream or core inputs
  always_comb begin
    s_ready  = (state == S_LOAD);
    busy     = (state == S_LOAD) || (state == S_HOLD) || (state == S_RUN);
    core_rst = !((state == S_RUN) || (state == S_DONE));
  end

  // Next-state selection; halt is checked before the cycle limit so a halt
  // landing in the limit cycle still counts as a normal finish
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_TOUT: begin
        if (start_load) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer && s_last) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (hold_last) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (core_halt) begin
          state_next = S_DONE;
        end else if (at_limit) begin
          state_next = S_TOUT;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Word pointer; once it has stepped past the last dmem word it freezes
  // and the wrapped flag marks every further word as discarded
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      ptr         <= '0;
      ptr_wrapped <= 1'b0;
    end else if (start_load) begin
      ptr         <= '0;
      ptr_wrapped <= 1'b0;
    end else if (xfer_write) begin
      ptr <= ptr + (ADDR_BITS + 1)'(1);
      if (ptr == {(ADDR_BITS + 1){1'b1}}) begin
        ptr_wrapped <= 1'b1;
      end
    end
  end

  // Registered imem write port, one-cycle pulse per word aimed at imem
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= xfer_write && !ptr[ADDR_BITS];
      if (xfer_write && !ptr[ADDR_BITS]) begin
        imem_waddr <= ptr[ADDR_BITS-1:0];
        imem_wdata <= s_data;
      end
    end
  end

  // Registered dmem write port, one-cycle pulse per word aimed at dmem
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      dmem_we    <= 1'b0;
      dmem_waddr <= '0;
      dmem_wdata <= '0;
    end else begin
      dmem_we <= xfer_write && ptr[ADDR_BITS];
      if (xfer_write && ptr[ADDR_BITS]) begin
        dmem_waddr <= ptr[ADDR_BITS-1:0];
        dmem_wdata <= s_data;
      end
    end
  end

  // Overflow is sticky: any word accepted after the pointer wrapped sets it
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      overflow <= 1'b0;
    end else if (start_load) begin
      overflow <= 1'b0;
    end else if (xfer && ptr_wrapped) begin
      overflow <= 1'b1;
    end
  end

  // Reset-hold timer, counts cycles spent in HOLD and restarts outside it
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      hold_cnt <= '0;
    end else if (state != S_HOLD) begin
      hold_cnt <= '0;
    end else if (!hold_last) begin
      hold_cnt <= hold_cnt + HOLD_W'(1);
    end
  end

  // Run cycle counter; it stops on the exit cycle so its final value is the
  // cycle in which halt or the limit was seen, and it saturates at all-ones
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      cycle_count <= '0;
    end else if (start_load) begin
      cycle_count <= '0;
    end else if ((state == S_RUN) && !core_halt && !at_limit && !cnt_saturated) begin
      cycle_count <= cycle_count + CNT_W'(1);
    end
  end

  // Sticky completion flags, set on the cycle the run ends
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      done    <= 1'b0;
      timeout <= 1'b0;
    end else if (start_load) begin
      done    <= 1'b0;
      timeout <= 1'b0;
    end else if (state == S_RUN) begin
      if (core_halt) begin
        done <= 1'b1;
      end else if (at_limit) begin
        timeout <= 1'b1;
      end
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running sum of every accepted word, discarded overflow words included
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      checksum <= '0;
    end else if (start_load) begin
      checksum <= '0;
    end else if (xfer) begin
      checksum <= checksum + s_data;
    end
  end
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed bench for prog_loader.
// Two instances share all inputs and run in lockstep: "a" uses the full
// 16-bit address space, "b" uses ADDR_BITS=2 so imem/dmem spill and
// overflow are reachable with short images. Both use MAX_CYCLES=1000.
// With LOADER_CHECKSUM_EN defined the checksum outputs are checked too.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        s_valid = 1'b0;
  logic [31:0] s_data = '0;
  logic        s_last = 1'b0;
  logic        core_halt = 1'b0;

  logic        a_s_ready, a_imem_we, a_dmem_we, a_core_rst, a_busy;
  logic        a_done, a_timeout, a_overflow;
  logic [15:0] a_imem_waddr, a_dmem_waddr;
  logic [31:0] a_imem_wdata, a_dmem_wdata, a_cycle_count;

  logic        b_s_ready, b_imem_we, b_dmem_we, b_core_rst, b_busy;
  logic        b_done, b_timeout, b_overflow;
  logic [1:0]  b_imem_waddr, b_dmem_waddr;
  logic [31:0] b_imem_wdata, b_dmem_wdata, b_cycle_count;

`ifdef LOADER_CHECKSUM_EN
  logic [31:0] a_checksum, b_checksum;
`endif

  int checks = 0;
  int passed = 0;

  logic [47:0] a_imem_q[$];
  logic [47:0] a_dmem_q[$];
  logic [47:0] b_imem_q[$];
  logic [47:0] b_dmem_q[$];

  always #5 clk = ~clk;

  prog_loader #(.ADDR_BITS(16), .RST_HOLD(5), .MAX_CYCLES(1000), .CNT_W(32)) a (
    .CLOCK(clk), .RESET(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(a_s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(a_imem_we), .imem_waddr(a_imem_waddr), .imem_wdata(a_imem_wdata),
    .dmem_we(a_dmem_we), .dmem_waddr(a_dmem_waddr), .dmem_wdata(a_dmem_wdata),
    .core_rst(a_core_rst), .core_halt(core_halt), .busy(a_busy),
    .done(a_done), .timeout(a_timeout), .overflow(a_overflow),
    .cycle_count(a_cycle_count)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(a_checksum)
`endif
  );

  prog_loader #(.ADDR_BITS(2), .RST_HOLD(5), .MAX_CYCLES(1000), .CNT_W(32)) b (
    .CLOCK(clk), .RESET(rst_n), .start(start),
    .s_valid(s_valid), .s_ready(b_s_ready), .s_data(s_data), .s_last(s_last),
    .imem_we(b_imem_we), .imem_waddr(b_imem_waddr), .imem_wdata(b_imem_wdata),
    .dmem_we(b_dmem_we), .dmem_waddr(b_dmem_waddr), .dmem_wdata(b_dmem_wdata),
    .core_rst(b_core_rst), .core_halt(core_halt), .busy(b_busy),
    .done(b_done), .timeout(b_timeout), .overflow(b_overflow),
    .cycle_count(b_cycle_count)
`ifdef LOADER_CHECKSUM_EN
    , .checksum(b_checksum)
`endif
  );

  // Record every write pulse of both instances as {addr, data}
  always @(negedge clk) begin
    if (a_imem_we) a_imem_q.push_back({a_imem_waddr, a_imem_wdata});
    if (a_dmem_we) a_dmem_q.push_back({a_dmem_waddr, a_dmem_wdata});
    if (b_imem_we) b_imem_q.push_back({14'd0, b_imem_waddr, b_imem_wdata});
    if (b_dmem_we) b_dmem_q.push_back({14'd0, b_dmem_waddr, b_dmem_wdata});
  end

  task automatic clear_logs();
    a_imem_q.delete(); a_dmem_q.delete();
    b_imem_q.delete(); b_dmem_q.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Offer one word and hold it until accepted; gap adds idle cycles after
  task automatic send_word(input logic [31:0] d, input logic l, input int gap);
    int guard;
    guard = 0;
    s_valid = 1'b1; s_data = d; s_last = l;
    while (a_s_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      $display("[TB] FAIL send_word: s_ready=%b never rose, required 1", a_s_ready);
    end
    @(posedge clk); #1;
    s_valid = 1'b0; s_last = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Wait (bounded) for core_rst to fall; n is cycles waited
  task automatic wait_run(output int n);
    n = 0;
    while (a_core_rst !== 1'b0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  // Bring a pending load to RUN and end it with a halt so start works again
  task automatic finish_run();
    int n;
    wait_run(n);
    if (n >= 50) begin
      checks++;
      $display("[TB] FAIL finish_run: core_rst=%b stuck, required 0", a_core_rst);
    end
    core_halt = 1'b1;
    @(posedge clk); #1;
    core_halt = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_s_ready, a_core_rst, a_busy, a_done, a_timeout, a_overflow, a_imem_we, a_dmem_we} !== 8'b0100_0000) begin
      $display("[TB] FAIL reset_flags: got %b required 01000000",
               {a_s_ready, a_core_rst, a_busy, a_done, a_timeout, a_overflow, a_imem_we, a_dmem_we});
    end else passed++;
    checks++;
    if ({a_cycle_count, a_imem_waddr, a_imem_wdata, a_dmem_waddr, a_dmem_wdata} !== '0) begin
      $display("[TB] FAIL reset_values: count=%0d iaddr=%h idata=%h daddr=%h ddata=%h required all 0",
               a_cycle_count, a_imem_waddr, a_imem_wdata, a_dmem_waddr, a_dmem_wdata);
    end else passed++;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_s_ready, a_core_rst, a_busy} !== 3'b010) begin
      $display("[TB] FAIL idle_after_reset: ready/rst/busy=%b required 010", {a_s_ready, a_core_rst, a_busy});
    end else passed++;
  endtask

  task automatic test_small_image();
    logic [31:0] img [6];
    logic [31:0] sum;
    int n;
    img = '{32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00302023, 32'h00000073, 32'h0};
    sum = '0;
    clear_logs();
    pulse_start();
    checks++;
    if ({a_s_ready, a_core_rst, a_busy} !== 3'b111) begin
      $display("[TB] FAIL load_entry: ready/rst/busy=%b required 111", {a_s_ready, a_core_rst, a_busy});
    end else passed++;
    for (int i = 0; i < 6; i++) begin
      send_word(img[i], (i == 5), 0);
      sum = sum + img[i];
    end
    wait_run(n);
    checks++;
    if (n !== 5) begin
      $display("[TB] FAIL hold_length: core_rst fell after %0d cycles, required 5", n);
    end else passed++;
    checks++;
    if (a_imem_q.size() !== 6 || a_dmem_q.size() !== 0) begin
      $display("[TB] FAIL small_write_count: imem=%0d dmem=%0d required 6 and 0", a_imem_q.size(), a_dmem_q.size());
    end else passed++;
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= a_imem_q.size() || a_imem_q[i] !== {16'(i), img[i]}) begin
        $display("[TB] FAIL small_imem_%0d: got %h required %h", i,
                 (i < a_imem_q.size()) ? a_imem_q[i] : 48'hx, {16'(i), img[i]});
      end else passed++;
    end
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (a_checksum !== sum) begin
      $display("[TB] FAIL small_checksum: got %h required %h", a_checksum, sum);
    end else passed++;
`endif
    checks++;
    if (a_cycle_count !== 32'd0 || a_busy !== 1'b1) begin
      $display("[TB] FAIL run_entry: count=%0d busy=%b required 0 and 1", a_cycle_count, a_busy);
    end else passed++;
    core_halt = 1'b1;
    @(posedge clk); #1;
    core_halt = 1'b0;
  endtask

  task automatic test_halt();
    int n;
    clear_logs();
    pulse_start();
    send_word(32'h00000073, 1'b1, 0);
    wait_run(n);
    checks++;
    if (n !== 5 || a_imem_q.size() !== 1 || a_imem_q[0] !== {16'd0, 32'h00000073}) begin
      $display("[TB] FAIL single_word: hold=%0d imem_writes=%0d required 5 and 1 at addr 0", n, a_imem_q.size());
    end else passed++;
    repeat (120) @(posedge clk);
    #1;
    core_halt = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({a_done, a_timeout, a_busy, a_core_rst} !== 4'b1000 || a_cycle_count !== 32'd120) begin
      $display("[TB] FAIL halt_120: done/tout/busy/rst=%b count=%0d required 1000 and 120",
               {a_done, a_timeout, a_busy, a_core_rst}, a_cycle_count);
    end else passed++;
    repeat (4) @(posedge clk);
    #1;
    core_halt = 1'b0;
    checks++;
    if (a_core_rst !== 1'b0 || a_done !== 1'b1 || a_cycle_count !== 32'd120) begin
      $display("[TB] FAIL done_hold: rst=%b done=%b count=%0d required 0, 1, 120", a_core_rst, a_done, a_cycle_count);
    end else passed++;
  endtask

  task automatic test_timeout();
    int n;
    pulse_start();
    checks++;
    if (a_done !== 1'b0 || a_cycle_count !== 32'd0) begin
      $display("[TB] FAIL start_clears: done=%b count=%0d required 0 and 0", a_done, a_cycle_count);
    end else passed++;
    send_word(32'h0000006F, 1'b1, 0);
    wait_run(n);
    repeat (999) @(posedge clk);
    #1;
    checks++;
    if (a_timeout !== 1'b0 || a_busy !== 1'b1 || a_cycle_count !== 32'd999) begin
      $display("[TB] FAIL pre_limit: timeout=%b busy=%b count=%0d required 0, 1, 999", a_timeout, a_busy, a_cycle_count);
    end else passed++;
    @(posedge clk); #1;
    checks++;
    if ({a_timeout, a_done, a_busy, a_core_rst} !== 4'b1001 || a_cycle_count !== 32'd999) begin
      $display("[TB] FAIL timeout: tout/done/busy/rst=%b count=%0d required 1001 and 999",
               {a_timeout, a_done, a_busy, a_core_rst}, a_cycle_count);
    end else passed++;
  endtask

  task automatic test_halt_at_limit();
    int n;
    pulse_start();
    checks++;
    if (a_timeout !== 1'b0) begin
      $display("[TB] FAIL start_clears_timeout: got %b required 0", a_timeout);
    end else passed++;
    send_word(32'h0000006F, 1'b1, 0);
    wait_run(n);
    repeat (999) @(posedge clk);
    #1;
    core_halt = 1'b1;
    @(posedge clk); #1;
    core_halt = 1'b0;
    checks++;
    if ({a_done, a_timeout, a_core_rst} !== 3'b100 || a_cycle_count !== 32'd999) begin
      $display("[TB] FAIL halt_at_limit: done/tout/rst=%b count=%0d required 100 and 999",
               {a_done, a_timeout, a_core_rst}, a_cycle_count);
    end else passed++;
  endtask

  task automatic test_spill();
    clear_logs();
    pulse_start();
    for (int i = 0; i < 7; i++) begin
      send_word(32'hC0DE_0000 + 32'(i), (i == 6), 1);
    end
    checks++;
    if (b_imem_q.size() !== 4 || b_dmem_q.size() !== 3 || b_overflow !== 1'b0) begin
      $display("[TB] FAIL spill_counts: imem=%0d dmem=%0d ovf=%b required 4, 3, 0",
               b_imem_q.size(), b_dmem_q.size(), b_overflow);
    end else passed++;
    for (int i = 0; i < 7; i++) begin
      logic [47:0] exp;
      logic [47:0] got;
      exp = {16'(i % 4), 32'hC0DE_0000 + 32'(i)};
      if (i < 4) got = (i < b_imem_q.size()) ? b_imem_q[i] : 48'hx;
      else       got = (i - 4 < b_dmem_q.size()) ? b_dmem_q[i-4] : 48'hx;
      checks++;
      if (got !== exp) begin
        $display("[TB] FAIL spill_word_%0d: got %h required %h", i, got, exp);
      end else passed++;
    end
    finish_run();
  endtask

  task automatic test_overflow();
    logic [31:0] sum;
    logic [31:0] w;
    sum = '0;
    clear_logs();
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      w = 32'(i + 1) * 32'h1357_9BDF;
      sum = sum + w;
      send_word(w, (i == 9), 0);
      if (i == 7) begin
        checks++;
        if (b_overflow !== 1'b0) begin
          $display("[TB] FAIL overflow_early: got %b required 0 after word 8", b_overflow);
        end else passed++;
      end
    end
    @(posedge clk); #1;
    checks++;
    if (b_overflow !== 1'b1 || a_overflow !== 1'b0) begin
      $display("[TB] FAIL overflow_flag: b=%b a=%b required 1 and 0", b_overflow, a_overflow);
    end else passed++;
    checks++;
    if (b_imem_q.size() !== 4 || b_dmem_q.size() !== 4) begin
      $display("[TB] FAIL overflow_writes: imem=%0d dmem=%0d required 4 and 4", b_imem_q.size(), b_dmem_q.size());
    end else passed++;
    checks++;
    if (b_dmem_q.size() < 4 || b_dmem_q[3] !== {16'd3, 32'd8 * 32'h1357_9BDF}) begin
      $display("[TB] FAIL overflow_last_dmem: got %h required %h",
               (b_dmem_q.size() >= 4) ? b_dmem_q[3] : 48'hx, {16'd3, 32'd8 * 32'h1357_9BDF});
    end else passed++;
`ifdef LOADER_CHECKSUM_EN
    checks++;
    if (b_checksum !== sum) begin
      $display("[TB] FAIL overflow_checksum: got %h required %h", b_checksum, sum);
    end else passed++;
`endif
    finish_run();
  endtask

  task automatic test_reset_midload();
    int n;
    pulse_start();
    for (int i = 0; i < 3; i++) begin
      send_word(32'hBAD0_0000 + 32'(i), 1'b0, 0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_s_ready, a_core_rst, a_busy, a_imem_we, a_done, a_overflow} !== 6'b010000 ||
        a_imem_waddr !== 16'd0 || a_imem_wdata !== 32'd0) begin
      $display("[TB] FAIL async_reset: ready/rst/busy/we/done/ovf=%b addr=%h data=%h required 010000, 0, 0",
               {a_s_ready, a_core_rst, a_busy, a_imem_we, a_done, a_overflow}, a_imem_waddr, a_imem_wdata);
    end else passed++;
    #3;
    rst_n = 1'b1;
    @(posedge clk); #1;
    clear_logs();
    pulse_start();
    send_word(32'h1111_1111, 1'b0, 0);
    send_word(32'h2222_2222, 1'b1, 0);
    wait_run(n);
    checks++;
    if (a_imem_q.size() !== 2 || a_imem_q[0] !== {16'd0, 32'h1111_1111} || a_imem_q[1] !== {16'd1, 32'h2222_2222}) begin
      $display("[TB] FAIL reload_from_zero: writes=%0d first=%h required 2 starting %h",
               a_imem_q.size(), (a_imem_q.size() > 0) ? a_imem_q[0] : 48'hx, {16'd0, 32'h1111_1111});
    end else passed++;
    repeat (2) @(posedge clk);
    #1;
    pulse_start();
    checks++;
    if ({a_busy, a_core_rst, a_s_ready} !== 3'b100 || a_cycle_count !== 32'd3) begin
      $display("[TB] FAIL start_in_run: busy/rst/ready=%b count=%0d required 100 and 3",
               {a_busy, a_core_rst, a_s_ready}, a_cycle_count);
    end else passed++;
    core_halt = 1'b1;
    @(posedge clk); #1;
    core_halt = 1'b0;
    checks++;
    if (a_done !== 1'b1 || a_cycle_count !== 32'd3) begin
      $display("[TB] FAIL halt_after_ignored_start: done=%b count=%0d required 1 and 3", a_done, a_cycle_count);
    end else passed++;
  endtask

  initial begin
    test_reset();
    test_small_image();
    test_halt();
    test_timeout();
    test_halt_at_limit();
    test_spill();
    test_overflow();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
